// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential step, stall, branch, call/return via a
// circular return-address stack with sticky overflow/underflow flags.
//
// Ports:
//   clk, reset        rising-edge clock, async active-high reset
//   stall             freeze PC, stack and flags for this edge
//   branch_en         load branch_target into PC
//   branch_target     branch / call destination
//   call_en           push out+STEP, load branch_target
//   ret_en            pop stack top into PC
//   out               registered current PC
//   ras_count         number of valid stack entries
//   ras_overflow      sticky: call pushed while stack full
//   ras_underflow     sticky: return issued while stack empty
module pc_sequencer #(
    parameter int                ADDR_W    = 32,
    parameter int                STEP      = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int                RAS_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         branch_en,
    input  logic [ADDR_W-1:0]            branch_target,
    input  logic                         call_en,
    input  logic                         ret_en,
    output logic [ADDR_W-1:0]            out,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] ras [RAS_DEPTH];
    logic [PTR_W-1:0]  top;
    logic [PTR_W-1:0]  top_nxt;
    logic [ADDR_W-1:0] out_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              ovf_nxt;
    logic              unf_nxt;
    logic              do_push;
    logic [ADDR_W-1:0] seq_pc;

    assign seq_pc = out + ADDR_W'(STEP);

    // Priority: stall > ret > call > branch > increment.
    // When full, the push lands on top+1, which is the oldest slot,
    // so the circular buffer keeps the newest RAS_DEPTH entries.
    always_comb begin
        out_nxt = out;
        top_nxt = top;
        cnt_nxt = ras_count;
        ovf_nxt = ras_overflow;
        unf_nxt = ras_underflow;
        do_push = 1'b0;
        if (!stall) begin
            if (ret_en) begin
                if (ras_count != '0) begin
                    out_nxt = ras[top];
                    top_nxt = top - PTR_W'(1);
                    cnt_nxt = ras_count - CNT_W'(1);
                end else begin
                    out_nxt = seq_pc;
                    unf_nxt = 1'b1;
                end
            end else if (call_en) begin
                do_push = 1'b1;
                top_nxt = top + PTR_W'(1);
                out_nxt = branch_target;
                if (ras_count == FULL) begin
                    ovf_nxt = 1'b1;
                end else begin
                    cnt_nxt = ras_count + CNT_W'(1);
                end
            end else if (branch_en) begin
                out_nxt = branch_target;
            end else begin
                out_nxt = seq_pc;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out           <= RESET_VEC;
            top           <= '0;
            ras_count     <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            out           <= out_nxt;
            top           <= top_nxt;
            ras_count     <= cnt_nxt;
            ras_overflow  <= ovf_nxt;
            ras_underflow <= unf_nxt;
        end
    end

    // Stack contents need no reset; only the count marks them valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            ras[top_nxt] <= seq_pc;
        end
    end

endmodule
